mmio_ctrl: RTL
==============

// Module: mmio_ctrl
// PURPOSE
//  Parametrised memory-mapped I/O controller and data memory for the MIPS core. It sits on the core's
//  data port and holds a word-addressed data RAM plus an MMIO window. The window contains a hex
//  display register, a synchronised and debounced switch port, and a sticky switch-edge register.
//  It also holds a 32-bit timer with compare and a single interrupt line. Reads are combinational,
//  so the single-cycle core needs no changes.
// PARAMETERS
//  DEPTH      4096  data RAM words; addr is a word index, valid RAM range 0..DEPTH-1
//  SW_W       16    switch input width (<=32)
//  HEX_W      16    hex output width (<=32)
//  DB_CYCLES  4     debounce length in clock edges (>=1)
//  HEX_ADDR   2000  hex register (RW)
//  SW_ADDR    2002  debounced switches (RO)
//  EDGE_ADDR  2003  sticky rising-edge flags (RO, W1C)
//  TMR_ADDR   2004  timer count (RW)
//  CMP_ADDR   2005  timer compare (RW)
//  CTRL_ADDR  2006  control/status (RW)
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  reset      in   1      asynchronous, active-high reset
//  memwrite   in   1      write strobe, sampled at posedge clk
//  memread    in   1      read qualifier; readdata is driven regardless, no read side effects
//  addr       in   32     word address
//  writedata  in   32     write data
//  readdata   out  32     combinational read data
//  sw         in   SW_W   asynchronous switch inputs
//  hex        out  HEX_W  hex register value
//  irq        out  1      level interrupt to the core
// BEHAVIOUR
//  - Reset (async): hex=0, sync/debounce/edge=0, timer=0, cmp=32'hFFFF_FFFF, CTRL=0, irq=0. RAM not cleared.
//  - Decode: the six MMIO addresses take priority over RAM; writes to them never touch RAM.
//    Any other addr<DEPTH is RAM. Any addr>=DEPTH that is not MMIO reads 0 and ignores writes.
//    Unused MMIO addresses in the 2000..2006 range behave as RAM.
//  - Read mux: RAM[addr] | {0,hex} | {0,sw_db} | {0,edge} | timer | cmp | {28'b0,eie,pend,tie,en}.
//  - Write: all writes take effect at posedge when memwrite=1; read-after-write returns new data next cycle.
//  - Switches: 2-flop synchroniser (sw_s2 valid 2 edges after sw changes).
//    sw_db takes sw_s2 on the DB_CYCLES-th consecutive edge that sees sw_s2 stable and !=sw_db.
//    Any sw_s2 change restarts the count. Clean step: visible at SW_ADDR after 2+DB_CYCLES edges.
//  - Edge: edge[i] is set on the cycle sw_db[i] goes 0->1 and stays set until cleared.
//    A write to EDGE_ADDR clears the bits where writedata=1. Simultaneous set and clear: set wins.
//  - Timer: increments each cycle when CTRL.en; wraps 32'hFFFF_FFFF->0.
//    A write to TMR_ADDR loads writedata and takes priority over the increment that cycle.
//  - Compare: pend is set on any edge where en && timer==cmp. The compare uses the pre-increment value.
//  - CTRL bits:
//    - [0] en, [1] tie, [3] eie: plain RW.
//    - [2] pend: a write of 1 clears it, a write of 0 has no effect.
//    - Simultaneous set and clear of pend: set wins.
//  - irq = (pend & tie) | (eie & |edge). Registered-source, combinational OR, no extra latency.
//  - Reset mid-operation clears the debounce counter and any in-progress count.
//    A reset asserted during memwrite discards the write.
// TESTING
//  1 Reset, write 32'h1234 @2000 -> hex=16'h1234, read @2000 = 32'h0000_1234; RAM[2000] unchanged.
//  2 sw 0->16'h00A5 held -> read @2002 =0 through edge 5, =32'h00A5 at edge 6 (DB_CYCLES=4).
//    Edge @2003 = 32'h00A5; write 32'h0005 @2003 -> 32'h00A0.
//  3 sw glitch 0->1->0 lasting 3 cycles -> sw_db and edge stay 0. Re-raise set and clear in same cycle -> bit stays 1.
//  4 cmp=10, CTRL=32'h3 -> pend and irq go 1 on the 11th edge after enable.
//    Write CTRL=32'h7 -> irq 0. Timer load 32'hFFFF_FFFF -> next cycle 0.
//  5 RAM write/read @0 and @DEPTH-1 round-trip. Write @DEPTH -> ignored, reads 0.
//  6 Assert reset mid-debounce and with a timer running -> all outputs and registers at reset values immediately.

Source files
------------

// File: rtl/mmio_ctrl.sv
// Data RAM plus MMIO window (hex, debounced switches, sticky switch edges, timer/compare, control)
// for the single-cycle MIPS data port. Reads are combinational; all state updates on posedge clk.
module mmio_ctrl #(
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned SW_W      = 16,
    parameter int unsigned HEX_W     = 16,
    parameter int unsigned DB_CYCLES = 4,
    parameter logic [31:0] HEX_ADDR  = 32'd2000,
    parameter logic [31:0] SW_ADDR   = 32'd2002,
    parameter logic [31:0] EDGE_ADDR = 32'd2003,
    parameter logic [31:0] TMR_ADDR  = 32'd2004,
    parameter logic [31:0] CMP_ADDR  = 32'd2005,
    parameter logic [31:0] CTRL_ADDR = 32'd2006
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic             memread,
    input  logic [31:0]      addr,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [SW_W-1:0]  sw,
    output logic [HEX_W-1:0] hex,
    output logic             irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DB_CYCLES + 1);

    logic [31:0]      ram [DEPTH];
    logic [AW-1:0]    ram_idx;
    logic             sel_hex, sel_sw, sel_edge, sel_tmr, sel_cmp, sel_ctrl, sel_mmio, sel_ram;
    logic             ram_we, ctrl_wr;

    logic [SW_W-1:0]  sw_s1, sw_s2, sw_db, sw_cand, edge_flags;
    logic [SW_W-1:0]  rise, edge_clr;
    logic [CW-1:0]    db_cnt, cnt_inc;
    logic             db_load;

    logic [31:0]      timer, cmp;
    logic             en, tie, pend, eie;

    // readdata does not depend on memread; it is accepted for interface compatibility only
    logic             unused_ok;
    assign unused_ok = &{1'b0, memread};

    // Address decode: MMIO registers win over RAM; out-of-range addresses are dead
    always_comb begin
        sel_hex  = (addr == HEX_ADDR);
        sel_sw   = (addr == SW_ADDR);
        sel_edge = (addr == EDGE_ADDR);
        sel_tmr  = (addr == TMR_ADDR);
        sel_cmp  = (addr == CMP_ADDR);
        sel_ctrl = (addr == CTRL_ADDR);
        sel_mmio = sel_hex | sel_sw | sel_edge | sel_tmr | sel_cmp | sel_ctrl;
        sel_ram  = !sel_mmio && (addr < 32'(DEPTH));
        ram_idx  = addr[AW-1:0];
        ram_we   = memwrite && sel_ram;
        ctrl_wr  = memwrite && sel_ctrl;
    end

    // RAM is never cleared; a write coinciding with reset is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (!reset && ram_we) begin
            ram[ram_idx] <= writedata;
        end
    end

    // Debounce: count consecutive edges with a stable synchronised value that differs from sw_db
    always_comb begin
        cnt_inc  = (sw_s2 == sw_cand) ? db_cnt + CW'(1) : CW'(1);
        db_load  = (sw_s2 != sw_db) && (cnt_inc == CW'(DB_CYCLES));
        rise     = db_load ? (sw_s2 & ~sw_db) : '0;
        edge_clr = (memwrite && sel_edge) ? writedata[SW_W-1:0] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1      <= '0;
            sw_s2      <= '0;
            sw_cand    <= '0;
            sw_db      <= '0;
            db_cnt     <= '0;
            edge_flags <= '0;
        end else begin
            sw_s1   <= sw;
            sw_s2   <= sw_s1;
            sw_cand <= sw_s2;
            if (sw_s2 == sw_db) begin
                db_cnt <= '0;
            end else if (db_load) begin
                sw_db  <= sw_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= cnt_inc;
            end
            // set wins over a simultaneous write-1-to-clear
            edge_flags <= (edge_flags & ~edge_clr) | rise;
        end
    end

    // Hex, timer, compare and control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex   <= '0;
            timer <= '0;
            cmp   <= 32'hFFFF_FFFF;
            en    <= 1'b0;
            tie   <= 1'b0;
            pend  <= 1'b0;
            eie   <= 1'b0;
        end else begin
            if (memwrite && sel_hex) begin
                hex <= writedata[HEX_W-1:0];
            end
            if (memwrite && sel_tmr) begin
                timer <= writedata;
            end else if (en) begin
                timer <= timer + 32'd1;
            end
            if (memwrite && sel_cmp) begin
                cmp <= writedata;
            end
            if (ctrl_wr) begin
                en  <= writedata[0];
                tie <= writedata[1];
                eie <= writedata[3];
            end
            // compare uses the pre-increment timer; set wins over write-1-to-clear
            pend <= (en && (timer == cmp)) || (pend && !(ctrl_wr && writedata[2]));
        end
    end

    always_comb begin
        readdata = 32'd0;
        if (sel_hex) begin
            readdata = 32'(hex);
        end else if (sel_sw) begin
            readdata = 32'(sw_db);
        end else if (sel_edge) begin
            readdata = 32'(edge_flags);
        end else if (sel_tmr) begin
            readdata = timer;
        end else if (sel_cmp) begin
            readdata = cmp;
        end else if (sel_ctrl) begin
            readdata = {28'd0, eie, pend, tie, en};
        end else if (sel_ram) begin
            readdata = ram[ram_idx];
        end
    end

    assign irq = (pend & tie) | (eie & (|edge_flags));

endmodule
